// File: rtl/stdout_uart_bridge.sv
// CPU stdout -> UART TX bridge: write handshake, circular FIFO and 8N1-style serializer.
// Optional STDOUT_CRLF_EN: a 0x0D frame is sent ahead of every 0x0A without consuming a FIFO entry.
module stdout_uart_bridge #(
  parameter int CLKS_PER_BIT = 104,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16,
  parameter int LEVEL_W      = $clog2(FIFO_DEPTH+1)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  output logic                 stall,
  output logic                 tx,
  output logic                 tx_busy,
  output logic [LEVEL_W-1:0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS+1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q;
  state_e               state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  logic                 full, empty, push, pop, baud_end, start_frame, ins_cr;
  logic [DATA_BITS-1:0] head, load_byte;

  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty    = (wptr_q == rptr_q);
  // Gated by rstn so the CPU is held off while the bridge is in reset.
  assign wr_ready = rstn & ~full;
  assign stall    = ~wr_ready;
  assign push     = wr_valid & wr_ready;
  assign pop      = start_frame & ~ins_cr;
  assign head     = mem_q[rptr_q[AW-1:0]];
  assign baud_end = (baud_q == CW'(CLKS_PER_BIT-1));

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign level   = LEVEL_W'(wptr_q - rptr_q);

`ifdef STDOUT_CRLF_EN
  logic cr_sent_q, cr_sent_d;

  assign ins_cr    = (head == DATA_BITS'('h0A)) && !cr_sent_q;
  assign load_byte = ins_cr ? DATA_BITS'('h0D) : head;

  // Set when the CR is launched, cleared when any byte is actually popped.
  always_comb begin
    cr_sent_d = cr_sent_q;
    if (start_frame) cr_sent_d = ins_cr;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cr_sent_q <= 1'b0;
    else       cr_sent_q <= cr_sent_d;
  end
`else
  assign ins_cr    = 1'b0;
  assign load_byte = head;
`endif

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    start_frame = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) start_frame = 1'b1;
      end
      START: begin
        if (baud_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BW'(DATA_BITS-1)) begin
            state_d = STOP;
            bit_d   = '0;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == BW'(STOP_BITS-1)) begin
            bit_d = '0;
            // Chain straight into the next start bit when more data waits.
            if (!empty) start_frame = 1'b1;
            else        state_d = IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          baud_d = baud_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (start_frame) begin
      state_d = START;
      baud_d  = '0;
      bit_d   = '0;
      shift_d = load_byte;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end
endmodule

// File: doc/stdout_uart_bridge.md
Name: stdout_uart_bridge

Overview:
Buffered bridge from the CPU stdout byte stream to a UART transmit pin. It replaces the ad-hoc edge-detect/start logic beside the CPU with three parts: a valid/ready handshake, a parametrised FIFO and a built-in parametrised serializer. It sits between the proc stdout port and the board TX pin. Its stall output drives the CPU enable, so no byte is ever lost.

Parameters:
CLKS_PER_BIT, 104, clk cycles per UART bit (≥2)
DATA_BITS, 8, bits per frame payload (5..8)
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 16, FIFO entries; power of two, ≥2
LEVEL_W, $clog2(FIFO_DEPTH+1), width of level output

Ports:
clk  in  1  single clock for everything
rstn  in  1  asynchronous, active-low reset
wr_data  in  DATA_BITS  byte from CPU stdout
wr_valid  in  1  wr_data valid
wr_ready  out  1  FIFO can accept; = !full, 0 while rstn low
stall  out  1  = !wr_ready; CPU halts while high
tx  out  1  UART line, idle high
tx_busy  out  1  frame in progress
level  out  LEVEL_W  FIFO occupancy, excluding the byte in the shifter

Behaviour:
- Reset (rstn low, async): tx=1, tx_busy=0, level=0, wr_ready=0, stall=1. FSM goes to IDLE, FIFO pointers clear, in-flight frame abandoned. tx returns high immediately, without waiting for a clock edge.
- Write handshake: a byte is accepted at a rising edge with wr_valid && wr_ready. Holding wr_valid while wr_ready=0 is legal and loses nothing.
- wr_ready depends only on full; there is no same-cycle pass-through of a pop. When full and popping in the same cycle, wr_ready stays 0 for that cycle.
- FIFO: circular buffer of FIFO_DEPTH entries. Pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. level updates on the edge of each push or pop; push and pop together leave level unchanged.
- FSM states: IDLE, START, DATA, STOP.
- IDLE → START when FIFO is non-empty. Same edge: pop the head into the shifter, set tx=0 and tx_busy=1.
- Latency: a byte written at edge N into an empty FIFO with FSM idle pops at edge N+1, so tx goes low after edge N+1.
- START lasts CLKS_PER_BIT cycles, then → DATA.
- DATA sends DATA_BITS bits LSB first, each CLKS_PER_BIT cycles, then → STOP.
- STOP holds tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- At the end of STOP: if the FIFO is non-empty, go directly to START with the next pop, giving zero idle gap. Otherwise go to IDLE with tx_busy=0.
- Frame length = (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles exactly.
- Baud counter runs from 0 to CLKS_PER_BIT-1 and resets on each bit boundary. Bit counter is $clog2(DATA_BITS+1) wide.
- A write during a frame never disturbs the shifter.

Optional Feature:
Macro STDOUT_CRLF_EN.
- Defined (DATA_BITS must be 8):
  - When the FIFO head is 0x0A and internal flag cr_sent=0, the FSM transmits a 0x0D frame without popping and sets cr_sent=1.
  - The next frame pops and sends the 0x0A, then clears cr_sent.
  - level does not change for the inserted 0x0D. Back-to-back timing is unchanged: CR and LF run with no gap between them.
  - cr_sent clears on reset.
- Undefined: bytes are sent verbatim; there is no cr_sent flag.

Test Plan:
Parameters for all tests: CLKS_PER_BIT=4, FIFO_DEPTH=4, DATA_BITS=8, STOP_BITS=1.
1. Reset: hold rstn=0 for 5 cycles → tx=1, tx_busy=0, level=0, wr_ready=0. Release rstn → wr_ready=1 on the first cycle.
2. Single byte: write 0x41 at edge N → tx low from N+1. tx sequence is 0,1,0,0,0,0,0,1,0,1, each bit 4 cycles. tx_busy high for exactly 40 cycles.
3. Fill/stall: hold wr_valid high with 0x01..0x06 while the line is idle.
   - 0x01 pops to the shifter; 0x02..0x05 fill the FIFO, so level=4 and wr_ready=0.
   - 0x06 is held and accepted only after the 0x02 pop at the first frame boundary (cycle 40 after the start).
   - Line output is 0x01..0x06 in order, with no gaps and no loss.
4. Back-to-back: two bytes 0xFF, 0x00 queued → the stop bit of frame 1 is followed immediately by the start bit of frame 2. Total tx_busy is 80 cycles contiguous.
5. Reset mid-frame: drop rstn at cycle 15 of a 0x55 frame with 2 bytes queued → tx=1 immediately (async), level=0. After release, the line stays idle with no residual frame.
6. STDOUT_CRLF_EN: write 0x41, 0x0A → frames 0x41, 0x0D, 0x0A are sent back-to-back (120 cycles). level goes 1→0 only when 0x0A pops. Without the macro, only 0x41 and 0x0A are sent (80 cycles).
